// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle ARMv8 control path: FSM states, opcode
// match patterns, SignOp / ALU codes and the instruction class enum.
package ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  typedef enum logic [3:0] {
    CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_ADDI, CL_SUBI,
    CL_LDUR, CL_STUR, CL_CBZ, CL_B, CL_MOVZ, CL_ILLEGAL
  } op_class_e;

  localparam logic [1:0] SIGN_I  = 2'b00;
  localparam logic [1:0] SIGN_D  = 2'b01;
  localparam logic [1:0] SIGN_CB = 2'b10;
  localparam logic [1:0] SIGN_B  = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef struct packed {
    logic [1:0] sign_op;
    logic       reg2loc;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_fields_t;

  // Opcode patterns: a bit takes part in the match only where its mask bit is 1.
  localparam logic [10:0] OP_ADD   = 11'b10001011000, MK_ADD  = 11'b11111111111;
  localparam logic [10:0] OP_SUB   = 11'b11001011000, MK_SUB  = 11'b11111111111;
  localparam logic [10:0] OP_AND   = 11'b10001010000, MK_AND  = 11'b11111111111;
  localparam logic [10:0] OP_ORR   = 11'b10101010000, MK_ORR  = 11'b11111111111;
  localparam logic [10:0] OP_ADDI  = 11'b10010001000, MK_ADDI = 11'b11111111110;
  localparam logic [10:0] OP_SUBI  = 11'b11010001000, MK_SUBI = 11'b11111111110;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010, MK_LDUR = 11'b11111111111;
  localparam logic [10:0] OP_STUR  = 11'b11111000000, MK_STUR = 11'b11111111111;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000, MK_CBZ  = 11'b11111111000;
  localparam logic [10:0] OP_B     = 11'b00010100000, MK_B    = 11'b11111100000;
  localparam logic [10:0] OP_MOVZ  = 11'b11010010100, MK_MOVZ = 11'b11111111100;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] mask);
    return ((op ^ pat) & mask) == 11'b0;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational decode of Instruction[31:21] into an instruction class and the
// control fields that stay fixed for the whole instruction.
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [10:0]  opcode_i,
  output op_class_e    cls_o,
  output ctrl_fields_t fields_o
);

  always_comb begin
    cls_o = CL_ILLEGAL;
    if      (op_match(opcode_i, OP_ADD,  MK_ADD))  cls_o = CL_ADD;
    else if (op_match(opcode_i, OP_SUB,  MK_SUB))  cls_o = CL_SUB;
    else if (op_match(opcode_i, OP_AND,  MK_AND))  cls_o = CL_AND;
    else if (op_match(opcode_i, OP_ORR,  MK_ORR))  cls_o = CL_ORR;
    else if (op_match(opcode_i, OP_ADDI, MK_ADDI)) cls_o = CL_ADDI;
    else if (op_match(opcode_i, OP_SUBI, MK_SUBI)) cls_o = CL_SUBI;
    else if (op_match(opcode_i, OP_LDUR, MK_LDUR)) cls_o = CL_LDUR;
    else if (op_match(opcode_i, OP_STUR, MK_STUR)) cls_o = CL_STUR;
    else if (op_match(opcode_i, OP_CBZ,  MK_CBZ))  cls_o = CL_CBZ;
    else if (op_match(opcode_i, OP_B,    MK_B))    cls_o = CL_B;
    else if (op_match(opcode_i, OP_MOVZ, MK_MOVZ)) cls_o = CL_MOVZ;
  end

  // R-type has no immediate; SignOp is parked at 00 for it and for ILLEGAL.
  always_comb begin
    fields_o = '0;
    case (cls_o)
      CL_ADD:  fields_o.alu_op = ALU_ADD;
      CL_SUB:  fields_o.alu_op = ALU_SUB;
      CL_AND:  fields_o.alu_op = ALU_AND;
      CL_ORR:  fields_o.alu_op = ALU_ORR;
      CL_ADDI: begin
        fields_o.sign_op = SIGN_I;
        fields_o.alu_src = 1'b1;
        fields_o.alu_op  = ALU_ADD;
      end
      CL_SUBI: begin
        fields_o.sign_op = SIGN_I;
        fields_o.alu_src = 1'b1;
        fields_o.alu_op  = ALU_SUB;
      end
      CL_LDUR: begin
        fields_o.sign_op = SIGN_D;
        fields_o.alu_src = 1'b1;
        fields_o.alu_op  = ALU_ADD;
      end
      CL_STUR: begin
        fields_o.sign_op = SIGN_D;
        fields_o.reg2loc = 1'b1;
        fields_o.alu_src = 1'b1;
        fields_o.alu_op  = ALU_ADD;
      end
      CL_CBZ: begin
        fields_o.sign_op = SIGN_CB;
        fields_o.reg2loc = 1'b1;
        fields_o.alu_op  = ALU_PASSB;
      end
      CL_B:    fields_o.sign_op = SIGN_B;
      CL_MOVZ: begin
        fields_o.sign_op = SIGN_I;
        fields_o.alu_src = 1'b1;
        fields_o.alu_op  = ALU_PASSB;
      end
      default: fields_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ARMv8 lab datapath,
// with memory handshakes, timeout-to-FAULT and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [1:0]       SignOp,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             mem2reg,
  output logic             reg_write,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [2:0]       state_q, state_d;
  logic             run_q;
  op_class_e        cls_q, cls_d, dec_cls;
  ctrl_fields_t     fld_q, fld_d, dec_fld, fld_out;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             tmo_hit, waiting;

  opcode_classifier u_cls (
    .opcode_i (opcode),
    .cls_o    (dec_cls),
    .fields_o (dec_fld)
  );

  // run_q holds FETCH quiet for the first cycle after reset so every output reads 0.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TW'(MEM_TIMEOUT - 1));
  assign waiting = (state_q == S_FETCH && run_q) || (state_q == S_MEM);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    fld_d   = fld_q;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          if (imem_ack)     state_d = S_DECODE;
          else if (tmo_hit) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        fld_d   = dec_fld;
        state_d = (dec_cls == CL_ILLEGAL) ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          CL_B, CL_CBZ:     state_d = S_FETCH;
          CL_LDUR, CL_STUR: state_d = S_MEM;
          default:          state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)     state_d = (cls_q == CL_STUR) ? S_FETCH : S_WB;
        else if (tmo_hit) state_d = S_FAULT;
      end
      S_WB:    state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Counter restarts whenever a wait state is (re)entered; ack on the last allowed cycle still wins.
  always_comb begin
    tmo_d = '0;
    if (MEM_TIMEOUT != 0 && waiting && state_d == state_q)
      tmo_d = tmo_q + TW'(1);
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    mem2reg   = 1'b0;
    reg_write = 1'b0;
    fault     = 1'b0;
    fld_out   = '0;
    case (state_q)
      S_FETCH: begin
        imem_req = run_q;
        ir_we    = run_q & imem_ack;
      end
      S_DECODE: fld_out = dec_fld;
      S_EXEC: begin
        fld_out = fld_q;
        if (cls_q == CL_B) begin
          pc_we  = 1'b1;
          pc_sel = 1'b1;
        end else if (cls_q == CL_CBZ) begin
          pc_we  = 1'b1;
          pc_sel = zero;
        end
      end
      S_MEM: begin
        fld_out   = fld_q;
        dmem_req  = 1'b1;
        mem_read  = (cls_q == CL_LDUR);
        mem_write = (cls_q == CL_STUR);
        pc_we     = dmem_ack & (cls_q == CL_STUR);
      end
      S_WB: begin
        fld_out   = fld_q;
        reg_write = 1'b1;
        mem2reg   = (cls_q == CL_LDUR);
        pc_we     = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b1;
    endcase
    SignOp  = fld_out.sign_op;
    reg2loc = fld_out.reg2loc;
    alu_src = fld_out.alu_src;
    alu_op  = fld_out.alu_op;
  end

  assign ret_d   = ret_q + (pc_we ? CNT_W'(1) : CNT_W'(0));
  assign retired = ret_q;

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      cls_q   <= CL_ILLEGAL;
      fld_q   <= '0;
      tmo_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      cls_q   <= cls_d;
      fld_q   <= fld_d;
      tmo_q   <= tmo_d;
      ret_q   <= ret_d;
    end
  end

endmodule
